// File: rtl/axi_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_rd_arbiter
// Description : Two-master to one-slave AXI4-Lite read-channel arbiter.
//               Round-robin grant, one outstanding single-beat read at a
//               time, and a per-phase watchdog that turns a hung slave into
//               a SLVERR response to the granted master.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_rd_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*ADDR_W-1:0]   m_araddr,
  input  logic [1:0]            m_arvalid,
  output logic [1:0]            m_arready,
  output logic [DATA_W-1:0]     m_rdata,
  output logic [1:0]            m_rresp,
  output logic [1:0]            m_rvalid,
  input  logic [1:0]            m_rready,
  output logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic                  grant,
  output logic                  timeout_err
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]        state;
  logic              last_grant;
  logic [WD_W-1:0]   wd_cnt;

  logic              wd_expire;
  logic              ar_hs;
  logic              r_hs;
  logic [ADDR_W-1:0] sel_addr;

  assign wd_expire = (wd_cnt == WD_LAST);
  assign ar_hs     = s_arvalid && s_arready;
  assign r_hs      = s_rvalid && s_rready;
  assign sel_addr  = grant ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];

  // Channel steering: route the granted master to the slave; everything is
  // forced low while rst is high so the slave sees valid/ready drop at once.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    if (!rst) begin
      case (state)
        ST_ADDR: begin
          // On expiry the request is accepted from the master but withheld
          // from the slave, so the slave never sees a late AR.
          s_arvalid        = m_arvalid[grant] && !wd_expire;
          s_araddr         = s_arvalid ? sel_addr : '0;
          m_arready[grant] = s_arready || wd_expire;
        end
        ST_DATA: begin
          m_rvalid[grant] = s_rvalid;
          if (s_rvalid) begin
            m_rdata = s_rdata;
            m_rresp = s_rresp;
          end
          // A beat arriving in the expiry cycle still completes normally;
          // only a missing beat lets the watchdog win.
          s_rready = m_rready[grant] && (!wd_expire || s_rvalid);
        end
        ST_ERR: begin
          m_rvalid[grant] = 1'b1;
          m_rresp         = RESP_SLVERR;
        end
        default: begin
          m_rvalid = '0;
        end
      endcase
    end
  end

  // Arbitration FSM, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_cnt <= '0;
          if (|m_arvalid) begin
            grant <= (&m_arvalid) ? ~last_grant : m_arvalid[1];
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ar_hs) begin
            wd_cnt <= '0;
            state  <= ST_DATA;
          end else if (wd_expire) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b1;
            state       <= ST_ERR;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            wd_cnt     <= '0;
            last_grant <= grant;
            state      <= ST_IDLE;
          end else if (wd_expire) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b1;
            state       <= ST_ERR;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_ERR: begin
          if (m_rready[grant]) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_rd_arbiter
// Description : Directed self-checking bench for axi_lite_rd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_rd_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 128;

  logic                clk;
  logic                rst;
  logic [2*ADDR_W-1:0] m_araddr;
  logic [1:0]          m_arvalid;
  logic [1:0]          m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic [1:0]          m_rvalid;
  logic [1:0]          m_rready;
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;
  logic                grant;
  logic                timeout_err;

  int errors;
  int checks;

  axi_lite_rd_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_araddr   (m_araddr),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  // 10 ns clock; inputs change on the falling edge, outputs sampled 1 ns later.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a scenario never reaches its end.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic idle_inputs();
    m_araddr  = '0;
    m_arvalid = '0;
    m_rready  = '0;
    s_arready = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rvalid  = 1'b0;
  endtask

  // One cycle of reset; returns on a falling edge with rst low, FSM in IDLE.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (m_arready !== 2'b00) begin errors++; $display("FAIL rst_arready got=%b exp=00", m_arready); end
    checks++; if (m_rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid got=%b exp=00", m_rvalid); end
    checks++; if (s_arvalid !== 1'b0 || s_rready !== 1'b0) begin errors++; $display("FAIL rst_slave got=%b%b exp=00", s_arvalid, s_rready); end
    checks++; if (s_araddr !== 32'h0 || m_rdata !== 32'h0 || m_rresp !== 2'b00) begin errors++; $display("FAIL rst_data got=%h/%h/%b exp=0", s_araddr, m_rdata, m_rresp); end
    checks++; if (grant !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_regs grant=%b terr=%b exp=0/0", grant, timeout_err); end
    rst = 1'b0;
  endtask

  task automatic test_single_m0();
    @(negedge clk);
    m_araddr[31:0] = 32'h0000_0100;
    m_arvalid      = 2'b01;
    s_arready      = 1'b1;
    #1;
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL single_idle_arvalid got=%b exp=0", s_arvalid); end
    @(negedge clk);
    #1;
    checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h0000_0100) begin errors++; $display("FAIL single_ar got=%b/%h exp=1/00000100", s_arvalid, s_araddr); end
    checks++; if (m_arready !== 2'b01 || grant !== 1'b0) begin errors++; $display("FAIL single_arready got=%b grant=%b exp=01/0", m_arready, grant); end
    @(negedge clk);
    m_arvalid = 2'b00;
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = 32'hDEAD_BEEF;
    s_rresp   = 2'b00;
    m_rready  = 2'b01;
    #1;
    checks++; if (m_rvalid !== 2'b01) begin errors++; $display("FAIL single_rvalid got=%b exp=01", m_rvalid); end
    checks++; if (m_rdata !== 32'hDEAD_BEEF || m_rresp !== 2'b00) begin errors++; $display("FAIL single_rdata got=%h/%b exp=deadbeef/00", m_rdata, m_rresp); end
    checks++; if (s_rready !== 1'b1 || m_arready !== 2'b00) begin errors++; $display("FAIL single_rready got=%b arready=%b exp=1/00", s_rready, m_arready); end
    @(negedge clk);
    s_rvalid = 1'b0;
    m_rready = 2'b00;
    #1;
    checks++; if (m_rvalid !== 2'b00 || s_arvalid !== 1'b0 || grant !== 1'b0) begin errors++; $display("FAIL single_done rvalid=%b arvalid=%b grant=%b exp=00/0/0", m_rvalid, s_arvalid, grant); end
  endtask

  // Both masters request continuously; a one-cycle-latency slave answers each
  // read with addr ^ A5A50000.
  task automatic test_back_to_back();
    logic [31:0] addr_q [4];
    int          ar_cyc [4];
    int          r_cyc  [4];
    int          n_ar;
    int          n_r;
    logic        pend;
    logic [31:0] pend_addr;
    for (int k = 0; k < 4; k++) begin addr_q[k] = '0; ar_cyc[k] = 0; r_cyc[k] = 0; end
    n_ar = 0; n_r = 0; pend = 1'b0; pend_addr = '0;
    do_reset();
    m_araddr  = {32'h0000_0020, 32'h0000_0010};
    m_arvalid = 2'b11;
    s_arready = 1'b1;
    m_rready  = 2'b11;
    for (int c = 0; c < 60 && n_r < 4; c++) begin
      if (c > 0) @(negedge clk);
      s_rvalid = pend;
      s_rdata  = pend ? (pend_addr ^ 32'hA5A5_0000) : 32'h0;
      s_rresp  = 2'b00;
      #1;
      if (s_arvalid && s_arready) begin
        if (n_ar < 4) begin addr_q[n_ar] = s_araddr; ar_cyc[n_ar] = c; end
        n_ar++;
        pend_addr = s_araddr;
        pend      = 1'b1;
      end else if (s_rvalid && s_rready) begin
        checks++; if (m_rvalid !== ((pend_addr == 32'h10) ? 2'b01 : 2'b10) || m_rdata !== (pend_addr ^ 32'hA5A5_0000)) begin errors++; $display("FAIL b2b_rbeat%0d rvalid=%b data=%h addr=%h", n_r, m_rvalid, m_rdata, pend_addr); end
        if (n_r < 4) r_cyc[n_r] = c;
        n_r++;
        pend = 1'b0;
        if (n_r == 4) m_arvalid = 2'b00;
      end
    end
    checks++; if (n_r !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", n_r); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (addr_q[k] !== ((k % 2 == 0) ? 32'h10 : 32'h20)) begin errors++; $display("FAIL b2b_order%0d got=%h exp=%h", k, addr_q[k], (k % 2 == 0) ? 32'h10 : 32'h20); end
    end
    checks++; if (ar_cyc[0] !== 1) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=1", ar_cyc[0]); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (ar_cyc[k] - r_cyc[k-1] !== 2) begin errors++; $display("FAIL b2b_bubble%0d got=%0d exp=2", k, ar_cyc[k] - r_cyc[k-1]); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Slave never accepts AR. The ADDR phase spans TIMEOUT cycles: TIMEOUT-1
  // with s_arvalid high, then the expiry cycle with s_arvalid forced low and
  // the master's AR accepted.
  task automatic test_ar_timeout();
    int   cnt_v;
    int   pulse_c;
    logic found;
    cnt_v = 0; pulse_c = -1; found = 1'b0;
    do_reset();
    m_araddr[63:32] = 32'h0000_3000;
    m_arvalid       = 2'b10;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (m_arready[1]) begin
        found   = 1'b1;
        pulse_c = c;
        checks++; if (s_arvalid !== 1'b0 || m_arready !== 2'b10 || timeout_err !== 1'b0) begin errors++; $display("FAIL arto_pulse arvalid=%b arready=%b terr=%b exp=0/10/0", s_arvalid, m_arready, timeout_err); end
        break;
      end
      if (s_arvalid) cnt_v++;
    end
    checks++; if (!found || pulse_c !== TIMEOUT) begin errors++; $display("FAIL arto_pulse_cycle got=%0d exp=%0d", pulse_c, TIMEOUT); end
    checks++; if (cnt_v !== TIMEOUT - 1) begin errors++; $display("FAIL arto_arvalid_cycles got=%0d exp=%0d", cnt_v, TIMEOUT - 1); end
    @(negedge clk);
    m_arvalid = 2'b00;
    #1;
    checks++; if (m_rvalid !== 2'b10 || m_rresp !== 2'b10 || m_rdata !== 32'h0) begin errors++; $display("FAIL arto_slverr rvalid=%b resp=%b data=%h exp=10/10/0", m_rvalid, m_rresp, m_rdata); end
    checks++; if (timeout_err !== 1'b1 || s_arvalid !== 1'b0 || s_rready !== 1'b0) begin errors++; $display("FAIL arto_err_flags terr=%b arvalid=%b rready=%b exp=1/0/0", timeout_err, s_arvalid, s_rready); end
    @(negedge clk);
    #1;
    checks++; if (m_rvalid !== 2'b10) begin errors++; $display("FAIL arto_err_hold got=%b exp=10", m_rvalid); end
    m_rready = 2'b10;
    @(negedge clk);
    m_rready = 2'b00;
    #1;
    checks++; if (m_rvalid !== 2'b00 || timeout_err !== 1'b1) begin errors++; $display("FAIL arto_after rvalid=%b terr=%b exp=00/1", m_rvalid, timeout_err); end
  endtask

  // R beat arrives exactly in the DATA expiry cycle: must complete normally.
  task automatic test_data_boundary();
    do_reset();
    m_araddr[31:0] = 32'h0000_0200;
    m_arvalid      = 2'b01;
    s_arready      = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (s_arvalid !== 1'b1) begin errors++; $display("FAIL bnd_ar got=%b exp=1", s_arvalid); end
    @(negedge clk);
    m_arvalid = 2'b00;
    s_arready = 1'b0;
    m_rready  = 2'b01;
    #1;
    checks++; if (s_rready !== 1'b1 || m_rvalid !== 2'b00) begin errors++; $display("FAIL bnd_data_entry rready=%b rvalid=%b exp=1/00", s_rready, m_rvalid); end
    repeat (TIMEOUT - 2) @(negedge clk);
    #1;
    checks++; if (timeout_err !== 1'b0 || m_rvalid !== 2'b00) begin errors++; $display("FAIL bnd_pre terr=%b rvalid=%b exp=0/00", timeout_err, m_rvalid); end
    @(negedge clk);
    s_rvalid = 1'b1;
    s_rdata  = 32'h1234_5678;
    s_rresp  = 2'b00;
    #1;
    checks++; if (m_rvalid !== 2'b01 || m_rdata !== 32'h1234_5678 || s_rready !== 1'b1) begin errors++; $display("FAIL bnd_beat rvalid=%b data=%h rready=%b exp=01/12345678/1", m_rvalid, m_rdata, s_rready); end
    @(negedge clk);
    s_rvalid = 1'b0;
    m_rready = 2'b00;
    #1;
    checks++; if (timeout_err !== 1'b0 || m_rvalid !== 2'b00 || m_rresp !== 2'b00) begin errors++; $display("FAIL bnd_done terr=%b rvalid=%b resp=%b exp=0/00/00", timeout_err, m_rvalid, m_rresp); end
  endtask

  // M0 back-pressures R for 10 cycles while M1 waits, then M1 is served.
  task automatic test_rready_backpressure();
    do_reset();
    m_araddr  = {32'h0000_4400, 32'h0000_0040};
    m_arvalid = 2'b01;
    s_arready = 1'b1;
    @(negedge clk);
    m_arvalid = 2'b11;
    #1;
    checks++; if (grant !== 1'b0 || m_arready !== 2'b01) begin errors++; $display("FAIL bp_grant grant=%b arready=%b exp=0/01", grant, m_arready); end
    @(negedge clk);
    m_arvalid = 2'b10;
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = 32'hCAFE_F00D;
    s_rresp   = 2'b00;
    m_rready  = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (s_rready !== 1'b0 || m_rvalid !== 2'b01 || m_rdata !== 32'hCAFE_F00D || m_arready !== 2'b00) begin errors++; $display("FAIL bp_hold%0d rready=%b rvalid=%b data=%h arready=%b exp=0/01/cafef00d/00", i, s_rready, m_rvalid, m_rdata, m_arready); end
    end
    @(negedge clk);
    m_rready = 2'b01;
    #1;
    checks++; if (s_rready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", s_rready); end
    @(negedge clk);
    s_rvalid  = 1'b0;
    m_rready  = 2'b00;
    s_arready = 1'b1;
    #1;
    checks++; if (s_arvalid !== 1'b0 || m_rvalid !== 2'b00) begin errors++; $display("FAIL bp_bubble arvalid=%b rvalid=%b exp=0/00", s_arvalid, m_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (grant !== 1'b1 || s_arvalid !== 1'b1 || s_araddr !== 32'h0000_4400 || m_arready !== 2'b10) begin errors++; $display("FAIL bp_m1_ar grant=%b arvalid=%b addr=%h arready=%b exp=1/1/00004400/10", grant, s_arvalid, s_araddr, m_arready); end
    @(negedge clk);
    m_arvalid = 2'b00;
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = 32'h0000_55AA;
    m_rready  = 2'b10;
    #1;
    checks++; if (m_rvalid !== 2'b10 || m_rdata !== 32'h0000_55AA) begin errors++; $display("FAIL bp_m1_r rvalid=%b data=%h exp=10/000055aa", m_rvalid, m_rdata); end
    @(negedge clk);
    s_rvalid = 1'b0;
    m_rready = 2'b00;
  endtask

  // rst pulse while M1's read is in DATA; M0 pending request is served after.
  task automatic test_reset_mid();
    do_reset();
    m_araddr  = {32'h0000_0900, 32'h0000_0800};
    m_arvalid = 2'b10;
    s_arready = 1'b1;
    @(negedge clk);
    m_arvalid = 2'b11;
    #1;
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL rmid_grant got=%b exp=1", grant); end
    @(negedge clk);
    m_arvalid = 2'b01;
    s_arready = 1'b0;
    m_rready  = 2'b11;
    rst       = 1'b1;
    #1;
    checks++; if (s_rready !== 1'b0 || s_arvalid !== 1'b0) begin errors++; $display("FAIL rmid_drop rready=%b arvalid=%b exp=0/0", s_rready, s_arvalid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (grant !== 1'b0 || s_arvalid !== 1'b0 || m_arready !== 2'b00 || m_rvalid !== 2'b00 || s_rready !== 1'b0) begin errors++; $display("FAIL rmid_idle grant=%b arvalid=%b arready=%b rvalid=%b rready=%b exp=0/0/00/00/0", grant, s_arvalid, m_arready, m_rvalid, s_rready); end
    @(negedge clk);
    #1;
    checks++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h0000_0800 || grant !== 1'b0) begin errors++; $display("FAIL rmid_regrant arvalid=%b addr=%h grant=%b exp=1/00000800/0", s_arvalid, s_araddr, grant); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single_m0();
    test_back_to_back();
    test_ar_timeout();
    test_data_boundary();
    test_rready_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
